// File: rtl/lcd_driver.sv
// Character-LCD bus driver: turns core register writes into timed RS/RW/DATA/EN bus
// cycles, with a one-entry pending slot, a sticky overrun flag and per-command wait.

module lcd_driver #(
  parameter int T_SETUP     = 2,
  parameter int T_EN        = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] lcd_word_i,
  output logic        lcd_on_o,
  output logic        lcd_en_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic [7:0]  lcd_data_o,
  output logic [31:0] status_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ENABLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_EXEC   = 3'd4
  } state_t;

  // A zero duration still occupies its state for one cycle.
  localparam logic [31:0] D_SETUP = (T_SETUP     < 1) ? 32'd1 : 32'(T_SETUP);
  localparam logic [31:0] D_EN    = (T_EN        < 1) ? 32'd1 : 32'(T_EN);
  localparam logic [31:0] D_HOLD  = (T_HOLD      < 1) ? 32'd1 : 32'(T_HOLD);
  localparam logic [31:0] D_EXEC  = (T_EXEC      < 1) ? 32'd1 : 32'(T_EXEC);
  localparam logic [31:0] D_LONG  = (T_EXEC_LONG < 1) ? 32'd1 : 32'(T_EXEC_LONG);

  // Clear display / return home need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic rw, input logic [7:0] data);
    logic long_s;
    long_s = 1'b0;
    if (!rs && !rw) begin
      case (data)
        8'h01, 8'h02, 8'h03: long_s = 1'b1;
        default:             long_s = 1'b0;
      endcase
    end else begin
      long_s = 1'b0;
    end
    return long_s;
  endfunction

  state_t      state_r, state_nx_s;
  logic [31:0] cnt_r, cnt_nx_s;
  logic        cur_rs_r, cur_rs_nx_s, cur_rw_r, cur_rw_nx_s;
  logic [7:0]  cur_data_r, cur_data_nx_s;
  logic        pend_full_r, pend_full_nx_s, pend_rs_r, pend_rs_nx_s, pend_rw_r, pend_rw_nx_s;
  logic [7:0]  pend_data_r, pend_data_nx_s;
  logic        ovr_r, ovr_nx_s, ovr_set_s;
  logic        prev_req_r, armed_r;
  logic        on_r, en_r, rs_r, rw_r, busy_r;
  logic [7:0]  data_r;
  logic        req_s, direct_s, active_nx_s;
  logic        unused_s;

  // armed_r stays low for the first cycle after reset so a bit already high is history.
  assign req_s       = armed_r & lcd_word_i[10] & ~prev_req_r;
  assign direct_s    = req_s & (state_r == ST_IDLE) & ~pend_full_r;
  assign active_nx_s = (state_nx_s != ST_IDLE);
  assign unused_s    = ^lcd_word_i[30:12];

  assign lcd_on_o   = on_r;
  assign lcd_en_o   = en_r;
  assign lcd_rs_o   = rs_r;
  assign lcd_rw_o   = rw_r;
  assign lcd_data_o = data_r;
  assign status_o   = {29'd0, ovr_r, pend_full_r, busy_r};

  // Next-state, shared down-counter, transfer/pending slot and overrun logic.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    cur_rs_nx_s    = cur_rs_r;
    cur_rw_nx_s    = cur_rw_r;
    cur_data_nx_s  = cur_data_r;
    pend_full_nx_s = pend_full_r;
    pend_rs_nx_s   = pend_rs_r;
    pend_rw_nx_s   = pend_rw_r;
    pend_data_nx_s = pend_data_r;
    ovr_set_s      = 1'b0;
    ovr_nx_s       = ovr_r;

    case (state_r)
      ST_IDLE: begin
        if (pend_full_r) begin
          state_nx_s     = ST_SETUP;
          cnt_nx_s       = D_SETUP;
          cur_rs_nx_s    = pend_rs_r;
          cur_rw_nx_s    = pend_rw_r;
          cur_data_nx_s  = pend_data_r;
          pend_full_nx_s = 1'b0;
        end else if (direct_s) begin
          state_nx_s    = ST_SETUP;
          cnt_nx_s      = D_SETUP;
          cur_rs_nx_s   = lcd_word_i[9];
          cur_rw_nx_s   = lcd_word_i[8];
          cur_data_nx_s = lcd_word_i[7:0];
        end else begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = 32'd0;
        end
      end
      ST_SETUP: begin
        if (cnt_r <= 32'd1) begin
          state_nx_s = ST_ENABLE;
          cnt_nx_s   = D_EN;
        end else begin
          cnt_nx_s = cnt_r - 32'd1;
        end
      end
      ST_ENABLE: begin
        if (cnt_r <= 32'd1) begin
          state_nx_s = ST_HOLD;
          cnt_nx_s   = D_HOLD;
        end else begin
          cnt_nx_s = cnt_r - 32'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_r <= 32'd1) begin
          state_nx_s = ST_EXEC;
          if (is_long_cmd(cur_rs_r, cur_rw_r, cur_data_r)) begin
            cnt_nx_s = D_LONG;
          end else begin
            cnt_nx_s = D_EXEC;
          end
        end else begin
          cnt_nx_s = cnt_r - 32'd1;
        end
      end
      ST_EXEC: begin
        if (cnt_r <= 32'd1) begin
          if (pend_full_r) begin
            state_nx_s     = ST_SETUP;
            cnt_nx_s       = D_SETUP;
            cur_rs_nx_s    = pend_rs_r;
            cur_rw_nx_s    = pend_rw_r;
            cur_data_nx_s  = pend_data_r;
            pend_full_nx_s = 1'b0;
          end else begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = 32'd0;
          end
        end else begin
          cnt_nx_s = cnt_r - 32'd1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 32'd0;
      end
    endcase

    // A request that cannot start now goes to the slot, or is dropped when the slot is full.
    if (req_s && !direct_s) begin
      if (pend_full_r) begin
        ovr_set_s = 1'b1;
      end else begin
        pend_full_nx_s = 1'b1;
        pend_rs_nx_s   = lcd_word_i[9];
        pend_rw_nx_s   = lcd_word_i[8];
        pend_data_nx_s = lcd_word_i[7:0];
      end
    end else begin
      ovr_set_s = 1'b0;
    end

    if (ovr_set_s) begin
      ovr_nx_s = 1'b1;
    end else if (lcd_word_i[11]) begin
      ovr_nx_s = 1'b0;
    end else begin
      ovr_nx_s = ovr_r;
    end
  end

  // State, slot and registered bus/status outputs; reset kills any transfer at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 32'd0;
      cur_rs_r    <= 1'b0;
      cur_rw_r    <= 1'b0;
      cur_data_r  <= 8'd0;
      pend_full_r <= 1'b0;
      pend_rs_r   <= 1'b0;
      pend_rw_r   <= 1'b0;
      pend_data_r <= 8'd0;
      ovr_r       <= 1'b0;
      prev_req_r  <= 1'b0;
      armed_r     <= 1'b0;
      on_r        <= 1'b0;
      en_r        <= 1'b0;
      rs_r        <= 1'b0;
      rw_r        <= 1'b0;
      data_r      <= 8'd0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      cur_rs_r    <= cur_rs_nx_s;
      cur_rw_r    <= cur_rw_nx_s;
      cur_data_r  <= cur_data_nx_s;
      pend_full_r <= pend_full_nx_s;
      pend_rs_r   <= pend_rs_nx_s;
      pend_rw_r   <= pend_rw_nx_s;
      pend_data_r <= pend_data_nx_s;
      ovr_r       <= ovr_nx_s;
      prev_req_r  <= lcd_word_i[10];
      armed_r     <= 1'b1;
      on_r        <= lcd_word_i[31];
      en_r        <= (state_nx_s == ST_ENABLE);
      rs_r        <= active_nx_s ? cur_rs_nx_s : 1'b0;
      rw_r        <= active_nx_s ? cur_rw_nx_s : 1'b0;
      data_r      <= active_nx_s ? cur_data_nx_s : 8'd0;
      busy_r      <= active_nx_s;
    end
  end

endmodule

// File: tb/tb_lcd_driver.sv
// Self-checking bench for lcd_driver: directed scenarios plus random register writes,
// compared every cycle against a transaction-window reference model.

module tb_lcd_driver;

  localparam int TS = 2;
  localparam int TE = 3;
  localparam int TH = 1;
  localparam int TX = 5;
  localparam int TL = 20;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] lcd_word_i;
  logic        lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o;
  logic [7:0]  lcd_data_o;
  logic [31:0] status_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  lcd_driver #(
    .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TL)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .lcd_word_i(lcd_word_i),
    .lcd_on_o(lcd_on_o), .lcd_en_o(lcd_en_o), .lcd_rs_o(lcd_rs_o),
    .lcd_rw_o(lcd_rw_o), .lcd_data_o(lcd_data_o), .status_o(status_o)
  );

  // Reference model: the active transfer is a window [t_start, t_end) of cycles.
  int          k;
  bit          act, pend_v, ovr, on_m, prev_m, armed;
  int          t_start, t_end;
  logic        t_rs, t_rw, p_rs, p_rw;
  logic [7:0]  t_data, p_data;

  function automatic int exec_len(input logic rs, input logic rw, input logic [7:0] d);
    return (!rs && !rw && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? TL : TX;
  endfunction

  function automatic void launch(input logic rs, input logic rw, input logic [7:0] d, input int n);
    act = 1'b1; t_start = n; t_end = n + TS + TE + TH + exec_len(rs, rw, d);
    t_rs = rs; t_rw = rw; t_data = d;
  endfunction

  function automatic void model_reset();
    k = 0; act = 1'b0; pend_v = 1'b0; ovr = 1'b0; on_m = 1'b0; prev_m = 1'b0; armed = 1'b0;
    t_start = 0; t_end = 0;
  endfunction

  function automatic void model_step(input logic [31:0] w);
    int n;
    bit busy_k, pf_k, req;
    n = k + 1; busy_k = act; pf_k = pend_v;
    req = armed && w[10] && !prev_m;
    if (req && !busy_k && !pf_k) launch(w[9], w[8], w[7:0], n);
    else if (req && !pf_k) begin pend_v = 1'b1; p_rs = w[9]; p_rw = w[8]; p_data = w[7:0]; end
    if (req && pf_k) ovr = 1'b1;
    else if (w[11]) ovr = 1'b0;
    if (busy_k && n == t_end) begin
      if (pf_k) begin launch(p_rs, p_rw, p_data, n); pend_v = 1'b0; end
      else act = 1'b0;
    end else if (!busy_k && pf_k) begin
      launch(p_rs, p_rw, p_data, n); pend_v = 1'b0;
    end
    on_m = w[31]; prev_m = w[10]; armed = 1'b1; k = n;
  endfunction

  function automatic logic [43:0] exp_vec();
    int   off;
    logic en;
    off = k - t_start;
    en  = act && off >= TS && off < TS + TE;
    return {on_m, en, act ? t_rs : 1'b0, act ? t_rw : 1'b0, act ? t_data : 8'h00,
            29'd0, ovr, pend_v, act};
  endfunction

  function automatic logic [43:0] obs_vec();
    return {lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o, status_o};
  endfunction

  task automatic drive(input logic [31:0] w);
    lcd_word_i = w;
    model_step(w);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    checks++;
    if (obs_vec() !== 44'd0) begin
      errors++; $display("FAIL reset_state got=%h exp=0", obs_vec());
    end
    rst_ni = 1'b1;
    drive(32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      drive(32'h0);
    end
  endtask

  task automatic test_on();
    bit pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL on_model cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (i > 0) begin
        checks++;
        if (lcd_on_o !== pat[i-1] || lcd_en_o !== 1'b0 || lcd_data_o !== 8'h00) begin
          errors++; $display("FAIL on_follow i=%0d got on=%b en=%b data=%h exp on=%b", i, lcd_on_o, lcd_en_o, lcd_data_o, pat[i-1]);
        end
      end
      drive((i < 8 && pat[i]) ? 32'h8000_0000 : 32'h0);
    end
  endtask

  task automatic test_single();
    int en_cnt = 0, busy_cnt = 0, first_en = -1;
    bit bus_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL single cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (lcd_en_o) begin en_cnt++; if (first_en < 0) first_en = i; end
      if (status_o[0]) begin
        busy_cnt++;
        if (lcd_rs_o !== 1'b1 || lcd_data_o !== 8'h41) bus_ok = 1'b0;
      end
      drive((i < 6) ? 32'h0000_0641 : 32'h0000_0241);
    end
    checks += 4;
    if (en_cnt != TE) begin errors++; $display("FAIL single_en_len got=%0d exp=%0d", en_cnt, TE); end
    if (first_en != TS + 1) begin errors++; $display("FAIL single_en_start got=%0d exp=%0d", first_en, TS + 1); end
    if (busy_cnt != 11) begin errors++; $display("FAIL single_busy got=%0d exp=11", busy_cnt); end
    if (!bus_ok) begin errors++; $display("FAIL single_bus got=changed exp=rs1_data41"); end
  endtask

  task automatic test_exec_len();
    logic [7:0] dv [2] = '{8'h01, 8'h38};
    int         ev [2] = '{TL, TX};
    for (int t = 0; t < 2; t++) begin
      int busy_cnt = 0;
      for (int i = 0; i < 32; i++) begin
        @(negedge clk_i);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL exec_len cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
        end
        if (status_o[0]) busy_cnt++;
        drive((i == 0) ? (32'h0000_0400 | {24'd0, dv[t]}) : {24'd0, dv[t]});
      end
      checks++;
      if (busy_cnt - (TS + TE + TH) != ev[t]) begin
        errors++; $display("FAIL exec_cycles data=%h got=%0d exp=%0d", dv[t], busy_cnt - (TS + TE + TH), ev[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt = 0, first_b = -1, last_b = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (i == 3) begin
        checks++;
        if (status_o !== 32'h3) begin errors++; $display("FAIL b2b_status got=%h exp=3", status_o); end
      end
      if (i == 14) begin
        checks++;
        if (lcd_en_o !== 1'b1 || lcd_data_o !== 8'h42) begin
          errors++; $display("FAIL b2b_second got en=%b data=%h exp en=1 data=42", lcd_en_o, lcd_data_o);
        end
      end
      if (status_o[0]) begin busy_cnt++; if (first_b < 0) first_b = i; last_b = i; end
      case (i)
        0:       drive(32'h0000_0641);
        1:       drive(32'h0000_0241);
        2:       drive(32'h0000_0642);
        default: drive(32'h0000_0242);
      endcase
    end
    checks++;
    if (busy_cnt != 22 || last_b - first_b + 1 != busy_cnt) begin
      errors++; $display("FAIL b2b_no_gap got busy=%0d span=%0d exp=22", busy_cnt, last_b - first_b + 1);
    end
  endtask

  task automatic test_overrun();
    bit saw33 = 1'b0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL overrun cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (i == 5) begin
        checks++;
        if (status_o !== 32'h7) begin errors++; $display("FAIL ovr_set got=%h exp=7", status_o); end
      end
      if (i == 30) begin
        checks++;
        if (status_o !== 32'h4) begin errors++; $display("FAIL ovr_sticky got=%h exp=4", status_o); end
      end
      if (i == 32) begin
        checks++;
        if (status_o !== 32'h0) begin errors++; $display("FAIL ovr_clear got=%h exp=0", status_o); end
      end
      if (status_o[0] && lcd_data_o === 8'h33) saw33 = 1'b1;
      case (i)
        0:       drive(32'h0000_0611);
        1:       drive(32'h0000_0211);
        2:       drive(32'h0000_0622);
        3:       drive(32'h0000_0222);
        4:       drive(32'h0000_0633);
        31:      drive(32'h0000_0800);
        default: drive(32'h0000_0233);
      endcase
    end
    checks++;
    if (saw33) begin errors++; $display("FAIL ovr_dropped got=seen exp=never"); end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL ovr_setwins cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (i == 5) begin
        checks++;
        if (status_o[2] !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got=%b exp=1", status_o[2]); end
      end
      case (i)
        0:       drive(32'h0000_0611);
        1:       drive(32'h0000_0211);
        2:       drive(32'h0000_0622);
        3:       drive(32'h0000_0222);
        4:       drive(32'h0000_0E33);
        28:      drive(32'h0000_0800);
        default: drive(32'h0000_0233);
      endcase
    end
  endtask

  task automatic test_reset_mid();
    int busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rst_mid_pre cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (i < 4) drive((i == 0) ? 32'h0000_0641 : 32'h0000_0241);
    end
    rst_ni = 1'b0;
    lcd_word_i = 32'h0000_0400;
    #1;
    checks++;
    if (lcd_en_o !== 1'b0 || status_o !== 32'h0 || obs_vec() !== 44'd0) begin
      errors++; $display("FAIL rst_mid_async got en=%b status=%h vec=%h exp all 0", lcd_en_o, status_o, obs_vec());
    end
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    drive(32'h0000_0400);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rst_mid_post cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (status_o[0]) busy_cnt++;
      drive((i < 14) ? 32'h0000_0400 : 32'h0);
    end
    checks++;
    if (busy_cnt != 0) begin errors++; $display("FAIL rst_no_request got busy=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      w       = 32'd0;
      w[31]   = 1'($urandom_range(0, 1));
      w[11]   = ($urandom_range(0, 15) == 0);
      w[10]   = ($urandom_range(0, 3) == 0);
      w[9:8]  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      w[7:0]  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      drive(w);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    lcd_word_i = 32'h0;
    model_reset();
    test_reset();
    test_on();
    test_single();
    test_exec_len();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
